hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised hazard and forwarding controller for the 5-stage pipeline, the successor to the two-operand EX forwarding logic. It generalises forwarding to NUM_SRC operands with fixed MEM-over-WB priority and adds load-use stall detection. It also adds a sequential scoreboard for one multi-cycle execution unit (mul/div) of latency MC_LAT. It sits between decode and execute and drives operand-mux selects, pipeline stall/flush, and multi-cycle writeback timing.

## Interface
- REG_AW, default 5: register address width.
- NUM_SRC, default 2: source operands per instruction.
- MC_LAT, default 4: multi-cycle unit latency in cycles; must be at least 2.
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- id_src  in  NUM_SRC*REG_AW  decode-stage source register addresses, operand i at bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  decode operand i actually read.
- id_rd, id_regwrite, id_mc_op  in  REG_AW,1,1  decode destination, write enable, and multi-cycle op flag.
- ex_src, ex_src_used  in  NUM_SRC*REG_AW, NUM_SRC  execute-stage sources.
- ex_rd, ex_regwrite, ex_memread  in  REG_AW,1,1  execute destination, write enable, and load flag.
- ex_mc_start  in  1  multi-cycle op leaving EX this cycle (destination = ex_rd).
- mem_rd, mem_regwrite  in  REG_AW,1  EX/MEM destination.
- wb_rd, wb_regwrite  in  REG_AW,1  MEM/WB destination.
- fwd_sel  out  NUM_SRC*2  per-EX-operand select: 00 register file, 10 MEM, 01 WB.
- stall_if, stall_id, flush_ex  out  1 each  hold PC/IF-ID, insert bubble into EX.
- mc_busy  out  1  multi-cycle unit occupied (registered).
- mc_wb_valid, mc_wb_rd  out  1, REG_AW  multi-cycle result writes back this cycle.

## Operation
- Forwarding, per operand i, evaluated in this order:
  - ex_src_used[i]=0 → 00.
  - mem_regwrite && mem_rd!=0 && mem_rd==src → 10.
  - else wb_regwrite && wb_rd!=0 && wb_rd==src → 01.
  - else 00.
  - MEM always beats WB, for every operand.
- Load-use hazard: ex_memread && ex_rd!=0 && ex_rd matches any used id_src → load-use stall.
- Scoreboard: pending bit per register, 2**REG_AW bits. Register 0 is never set.
- FSM states: MC_IDLE, MC_BUSY.
  - MC_IDLE + ex_mc_start (ex_rd!=0 or 0): → MC_BUSY, cnt=MC_LAT-1, pending[ex_rd]=1 unless ex_rd==0, latch mc_rd.
  - MC_BUSY, cnt!=0: cnt-1 each cycle.
  - MC_BUSY, cnt==0: mc_wb_valid=1, mc_wb_rd=latched rd. On the next edge → MC_IDLE and clear pending[rd].
- ex_mc_start while MC_BUSY is a protocol violation and is ignored. A bench assertion flags it.
- Scoreboard stall when either holds:
  - any used id_src has its pending bit set, or id_regwrite && pending[id_rd] (WAW);
  - id_mc_op && mc_busy (structural).
- The scoreboard stall still applies in the completion cycle; pending ID readers are released the cycle after mc_wb_valid.
- stall_if = stall_id = flush_ex = load-use stall OR scoreboard stall.
- rst=1: fwd_sel=0, stalls/flush=0, state MC_IDLE, cnt=0, pending all 0, mc_wb_valid=0, mc_busy=0. Asserting rst mid-operation abandons the in-flight op; no writeback pulse.

## Timing
- fwd_sel, stall_if, stall_id, and flush_ex are combinational from inputs and registered state (zero latency).
- mc_busy and mc_wb_valid derive only from registers (glitch-free).
- With ex_mc_start sampled at edge T0: mc_busy is high for MC_LAT cycles after T0, and mc_wb_valid is high only in the last of them.
- Back-to-back: an ID multi-cycle op stalled by mc_busy reaches EX in the first MC_IDLE cycle. Its start is accepted at the following edge, with no idle gap beyond that.
- cnt width is $clog2(MC_LAT). Counting is unsigned and never wraps below 0.

## Structure
- Package hazard_pkg:
  - fwd_sel encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - mc_state_t enum {MC_IDLE, MC_BUSY}.
- Sub-module fwd_src_sel: one operand's compare and priority logic, instantiated NUM_SRC times via generate.
- Scoreboard, FSM, and stall OR-ing stay in the top module.

## Test plan
- ex_src0=3, used; mem_rd=3 and wb_rd=3, both regwrite → fwd_sel[1:0]=10. Then wb only → 01. Then mem_rd=0, wb_rd=0 → 00.
- ex_memread, ex_rd=7; id_src1=7, used → stall_if/stall_id/flush_ex=1 for exactly one cycle. With id_src_used[1]=0 → no stall.
- ex_mc_start, ex_rd=9, MC_LAT=4 → mc_busy for 4 cycles, mc_wb_valid+mc_wb_rd=9 in cycle 4. An ID reader of r9 stalls through cycle 4 and is released in cycle 5.
- id_mc_op while busy → stall until MC_IDLE. The second op starts immediately after, and its mc_wb_valid comes exactly MC_LAT cycles after its start edge.
- ex_mc_start with ex_rd=0 → busy for MC_LAT cycles, no pending bit set, no ID stall on src=0.
- rst pulse in cycle 2 of a busy op → all outputs 0 immediately, no mc_wb_valid afterwards, pending cleared.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   FWD_*      : operand-mux select encodings driven on fwd_sel_o
//   mc_state_t : multi-cycle unit occupancy state
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MC_IDLE,
    MC_BUSY
  } mc_state_t;

endpackage

// File: rtl/fwd_src_sel.sv
// Forwarding select for a single EX operand.
//   src_i/used_i              : EX operand register address and read flag
//   mem_rd_i/mem_regwrite_i   : EX/MEM destination and write enable
//   wb_rd_i/wb_regwrite_i     : MEM/WB destination and write enable
//   sel_o                     : FWD_RF, FWD_MEM or FWD_WB
// MEM is the younger producer, so it always wins over WB.
module fwd_src_sel #(
  parameter int unsigned RegAw = 5
) (
  input  logic [RegAw-1:0] src_i,
  input  logic             used_i,
  input  logic [RegAw-1:0] mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [RegAw-1:0] wb_rd_i,
  input  logic             wb_regwrite_i,
  output logic [1:0]       sel_o
);
  import hazard_pkg::*;

  always_comb begin
    sel_o = FWD_RF;
    if (!used_i) begin
      sel_o = FWD_RF;
    end else if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   id_*                   : decode-stage sources, destination, write enable, multi-cycle flag
//   ex_*                   : execute-stage sources, destination, write/load flags, mc start
//   mem_rd_i/mem_regwrite_i, wb_rd_i/wb_regwrite_i : older producers for forwarding
//   fwd_sel_o              : 2-bit select per EX operand
//   stall_if_o/stall_id_o/flush_ex_o : load-use or scoreboard stall
//   mc_busy_o, mc_wb_valid_o, mc_wb_rd_o : multi-cycle unit status and writeback
module hazard_fwd_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned MC_LAT  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_mc_op_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
  input  logic [NUM_SRC-1:0]        ex_src_used_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic                      ex_regwrite_i,
  input  logic                      ex_memread_i,
  input  logic                      ex_mc_start_i,
  input  logic [REG_AW-1:0]         mem_rd_i,
  input  logic                      mem_regwrite_i,
  input  logic [REG_AW-1:0]         wb_rd_i,
  input  logic                      wb_regwrite_i,
  output logic [NUM_SRC*2-1:0]      fwd_sel_o,
  output logic                      stall_if_o,
  output logic                      stall_id_o,
  output logic                      flush_ex_o,
  output logic                      mc_busy_o,
  output logic                      mc_wb_valid_o,
  output logic [REG_AW-1:0]         mc_wb_rd_o
);
  import hazard_pkg::*;

  localparam int unsigned CntW    = $clog2(MC_LAT);
  localparam int unsigned NumRegs = 2 ** REG_AW;
  localparam logic [CntW-1:0] CntInit = CntW'(MC_LAT - 1);

  mc_state_t          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic [NumRegs-1:0] pending_q, pending_d;

  logic                 busy;
  logic [NUM_SRC*2-1:0] fwd_raw;
  logic                 load_use;
  logic                 sb_raw;
  logic                 sb_stall;
  logic                 stall;

  assign busy = (state_q == MC_BUSY);

  // Forwarding: one compare/priority slice per EX operand.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_src_sel #(
      .RegAw(REG_AW)
    ) u_fwd_src_sel (
      .src_i         (ex_src_i[i*REG_AW +: REG_AW]),
      .used_i        (ex_src_used_i[i]),
      .mem_rd_i      (mem_rd_i),
      .mem_regwrite_i(mem_regwrite_i),
      .wb_rd_i       (wb_rd_i),
      .wb_regwrite_i (wb_regwrite_i),
      .sel_o         (fwd_raw[i*2 +: 2])
    );
  end

  // Load-use and scoreboard RAW checks over all used ID operands.
  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used_i[i]) begin
        if (ex_memread_i && (ex_rd_i != '0) && (ex_rd_i == id_src_i[i*REG_AW +: REG_AW])) begin
          load_use = 1'b1;
        end
        if (pending_q[id_src_i[i*REG_AW +: REG_AW]]) begin
          sb_raw = 1'b1;
        end
      end
    end
  end

  // Pending bits stay set through the completion cycle, so readers release one cycle later.
  assign sb_stall = sb_raw || (id_regwrite_i && pending_q[id_rd_i]) || (id_mc_op_i && busy);
  assign stall    = !rst_i && (load_use || sb_stall);

  assign fwd_sel_o  = rst_i ? '0 : fwd_raw;
  assign stall_if_o = stall;
  assign stall_id_o = stall;
  assign flush_ex_o = stall;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= MC_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      pending_q <= pending_d;
    end
  end

  // Next-state and scoreboard update. A start while busy is ignored.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    pending_d = pending_q;
    unique case (state_q)
      MC_IDLE: begin
        if (ex_mc_start_i) begin
          state_d = MC_BUSY;
          cnt_d   = CntInit;
          rd_d    = ex_rd_i;
          if (ex_rd_i != '0) begin
            pending_d[ex_rd_i] = 1'b1;
          end
        end
      end
      MC_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d         = MC_IDLE;
          pending_d[rd_q] = 1'b0;
        end
      end
      default: state_d = MC_IDLE;
    endcase
    pending_d[0] = 1'b0;
  end

  // Outputs from registered state only.
  always_comb begin
    mc_busy_o     = busy;
    mc_wb_valid_o = busy && (cnt_q == '0);
    mc_wb_rd_o    = mc_wb_valid_o ? rd_q : '0;
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned MC_LAT  = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_regwrite;
  logic                      id_mc_op;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic [NUM_SRC-1:0]        ex_src_used;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_regwrite;
  logic                      ex_memread;
  logic                      ex_mc_start;
  logic [REG_AW-1:0]         mem_rd;
  logic                      mem_regwrite;
  logic [REG_AW-1:0]         wb_rd;
  logic                      wb_regwrite;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall_if;
  logic                      stall_id;
  logic                      flush_ex;
  logic                      mc_busy;
  logic                      mc_wb_valid;
  logic [REG_AW-1:0]         mc_wb_rd;

  hazard_fwd_unit #(
    .REG_AW (REG_AW),
    .NUM_SRC(NUM_SRC),
    .MC_LAT (MC_LAT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_src_i      (id_src),
    .id_src_used_i (id_src_used),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_mc_op_i    (id_mc_op),
    .ex_src_i      (ex_src),
    .ex_src_used_i (ex_src_used),
    .ex_rd_i       (ex_rd),
    .ex_regwrite_i (ex_regwrite),
    .ex_memread_i  (ex_memread),
    .ex_mc_start_i (ex_mc_start),
    .mem_rd_i      (mem_rd),
    .mem_regwrite_i(mem_regwrite),
    .wb_rd_i       (wb_rd),
    .wb_regwrite_i (wb_regwrite),
    .fwd_sel_o     (fwd_sel),
    .stall_if_o    (stall_if),
    .stall_id_o    (stall_id),
    .flush_ex_o    (flush_ex),
    .mc_busy_o     (mc_busy),
    .mc_wb_valid_o (mc_wb_valid),
    .mc_wb_rd_o    (mc_wb_rd)
  );

  typedef struct {
    string       name;
    logic [3:0]  fwd;
    logic        stall;
    logic        busy;
    logic        wbv;
    logic [4:0]  wbrd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the outputs at the falling edge.
  always @(negedge clk) begin
    assert (!(ex_mc_start && mc_busy)) else $error("protocol: ex_mc_start while mc_busy");
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (fwd_sel !== e.fwd || stall_if !== e.stall || stall_id !== e.stall ||
          flush_ex !== e.stall || mc_busy !== e.busy || mc_wb_valid !== e.wbv ||
          mc_wb_rd !== e.wbrd) begin
        failures++;
        $display("FAIL %s: got fwd=%b stall_if/id/flush=%b%b%b busy=%b wbv=%b wbrd=%0d; want fwd=%b stall=%b busy=%b wbv=%b wbrd=%0d",
                 e.name, fwd_sel, stall_if, stall_id, flush_ex, mc_busy, mc_wb_valid, mc_wb_rd,
                 e.fwd, e.stall, e.busy, e.wbv, e.wbrd);
      end
    end
  end

  task automatic expect_out(input string n, input logic [3:0] f, input logic s,
                            input logic b, input logic v, input logic [4:0] r);
    exp_t x;
    x.name = n; x.fwd = f; x.stall = s; x.busy = b; x.wbv = v; x.wbrd = r;
    q.push_back(x);
  endtask

  task automatic clr_in();
    id_src = '0; id_src_used = '0; id_rd = '0; id_regwrite = 1'b0; id_mc_op = 1'b0;
    ex_src = '0; ex_src_used = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    ex_mc_start = 1'b0; mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start for rd in the current cycle; the op is accepted at the next edge.
  task automatic mc_start(input logic [4:0] rd);
    tick(); clr_in();
    ex_mc_start = 1'b1; ex_rd = rd;
    expect_out("mc_start_cycle", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    // Hazard-inducing inputs while reset is held: every output must stay 0.
    ex_src[4:0] = 5'd3; ex_src_used = 2'b01; mem_rd = 5'd3; mem_regwrite = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd7; id_src[9:5] = 5'd7; id_src_used = 2'b10;
    #1;
    expect_out("reset_outputs", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    expect_out("reset_outputs_held", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); rst = 1'b0; clr_in();
    expect_out("idle_after_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

    // Forwarding on operand 0.
    tick(); clr_in();
    ex_src[4:0] = 5'd3; ex_src_used = 2'b01;
    mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1;
    expect_out("fwd0_mem_over_wb", 4'b0010, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); mem_regwrite = 1'b0;
    expect_out("fwd0_wb_only", 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    expect_out("fwd0_r0_never", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

    // Forwarding on operand 1.
    tick(); clr_in();
    ex_src[9:5] = 5'd6; ex_src_used = 2'b10;
    mem_rd = 5'd6; mem_regwrite = 1'b1; wb_rd = 5'd6; wb_regwrite = 1'b1;
    expect_out("fwd1_mem_over_wb", 4'b1000, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); mem_rd = 5'd8;
    expect_out("fwd1_wb_mem_differs", 4'b0100, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); ex_src_used = 2'b00;
    expect_out("fwd1_unused", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); ex_src[4:0] = 5'd6; ex_src_used = 2'b11; mem_rd = 5'd6;
    expect_out("fwd_both_mem", 4'b1010, 1'b0, 1'b0, 1'b0, 5'd0);

    // Load-use stall for one cycle, then the bubble clears it.
    tick(); clr_in();
    ex_memread = 1'b1; ex_rd = 5'd7; id_src[9:5] = 5'd7; id_src_used = 2'b10;
    expect_out("load_use_stall", 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0);
    tick(); ex_memread = 1'b0; ex_rd = 5'd0;
    expect_out("load_use_released", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); ex_memread = 1'b1; ex_rd = 5'd7; id_src_used = 2'b01;
    expect_out("load_use_src_unused", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); clr_in(); ex_memread = 1'b1; ex_rd = 5'd0; id_src_used = 2'b01;
    expect_out("load_use_r0", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

    // Multi-cycle op to r9: RAW reader and WAW writer stall while pending.
    mc_start(5'd9);
    for (int k = 1; k <= MC_LAT; k++) begin
      tick(); clr_in();
      if (k == 3) begin
        id_regwrite = 1'b1; id_rd = 5'd10;
        expect_out("mc9_unrelated_write", 4'b0000, 1'b0, 1'b1, 1'b0, 5'd0);
      end else if (k == 2) begin
        id_regwrite = 1'b1; id_rd = 5'd9;
        expect_out("mc9_waw_stall", 4'b0000, 1'b1, 1'b1, 1'b0, 5'd0);
      end else begin
        id_src[4:0] = 5'd9; id_src_used = 2'b01;
        expect_out("mc9_raw_stall", 4'b0000, 1'b1, 1'b1, k == MC_LAT, (k == MC_LAT) ? 5'd9 : 5'd0);
      end
    end
    tick(); clr_in(); id_src[4:0] = 5'd9; id_src_used = 2'b01;
    expect_out("mc9_reader_released", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

    // Back-to-back: ID mc op stalls on busy, second op starts in first idle cycle.
    mc_start(5'd11);
    for (int k = 1; k <= MC_LAT; k++) begin
      tick(); clr_in(); id_mc_op = 1'b1;
      expect_out("b2b_structural_stall", 4'b0000, 1'b1, 1'b1, k == MC_LAT,
                 (k == MC_LAT) ? 5'd11 : 5'd0);
    end
    tick(); clr_in();
    ex_mc_start = 1'b1; ex_rd = 5'd12; id_src[4:0] = 5'd11; id_src_used = 2'b01;
    expect_out("b2b_second_start", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 1; k <= MC_LAT; k++) begin
      tick(); clr_in(); id_src[4:0] = 5'd12; id_src_used = 2'b01;
      expect_out("b2b_second_busy", 4'b0000, 1'b1, 1'b1, k == MC_LAT,
                 (k == MC_LAT) ? 5'd12 : 5'd0);
    end
    tick(); clr_in(); id_src[4:0] = 5'd12; id_src_used = 2'b01;
    expect_out("b2b_second_done", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

    // Multi-cycle op with rd=0: busy but nothing pending.
    mc_start(5'd0);
    for (int k = 1; k <= MC_LAT; k++) begin
      tick(); clr_in(); id_src_used = 2'b11; id_regwrite = 1'b1;
      expect_out("mc_r0_no_pending", 4'b0000, 1'b0, 1'b1, k == MC_LAT, 5'd0);
    end
    tick(); clr_in();
    expect_out("mc_r0_done", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

    // Reset in cycle 2 of a busy op abandons it.
    mc_start(5'd13);
    tick(); clr_in(); id_src[4:0] = 5'd13; id_src_used = 2'b01;
    expect_out("rst_op_cycle1", 4'b0000, 1'b1, 1'b1, 1'b0, 5'd0);
    tick(); rst = 1'b1; ex_src[4:0] = 5'd13; ex_src_used = 2'b01;
    wb_rd = 5'd13; wb_regwrite = 1'b1;
    expect_out("rst_mid_op", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 3; k <= MC_LAT + 2; k++) begin
      tick(); rst = 1'b0; clr_in(); id_src[4:0] = 5'd13; id_src_used = 2'b01;
      expect_out("rst_op_abandoned", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
    end

    tick(); clr_in();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
